// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffered command front-end for the combinational ALU stage.
// Commands (x, y, sel) are queued in a DEPTH-entry FIFO; the head entry drives
// the ALU inputs and the ALU result is captured in a handshaked result register.
// Optional feature macro: ALU_ISSUE_DZ_TRAP_EN enables the divide/modulo-by-zero
// trap (result forced to all ones, res_dz raised). Undefined: result passes through.
module alu_issue_queue #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_x,
    input  logic [N-1:0]               in_y,
    input  logic [2:0]                 in_sel,
    output logic [N-1:0]               alu_x,
    output logic [N-1:0]               alu_y,
    output logic [2:0]                 alu_sel,
    input  logic [2*N-1:0]             alu_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2*N-1:0]             res_data,
    output logic [2:0]                 res_sel,
    output logic                       res_dz,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [N-1:0]  mem_x   [DEPTH];
    logic [N-1:0]  mem_y   [DEPTH];
    logic [2:0]    mem_sel [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic not_empty;
    logic push;
    logic load;
    logic dz_hit;

    assign not_empty = (count != '0);
    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign load      = not_empty && (!res_valid || res_ready);

    // Head entry drives the ALU; outputs read zero while the queue is empty.
    always_comb begin
        alu_x   = '0;
        alu_y   = '0;
        alu_sel = '0;
        if (not_empty) begin
            alu_x   = mem_x[rd_ptr];
            alu_y   = mem_y[rd_ptr];
            alu_sel = mem_sel[rd_ptr];
        end
    end

`ifdef ALU_ISSUE_DZ_TRAP_EN
    // Division and modulo with a zero divisor have no defined result.
    assign dz_hit = ((alu_sel == 3'b011) || (alu_sel == 3'b101)) && (alu_y == '0);
`else
    assign dz_hit = 1'b0;
`endif

    // FIFO storage write; contents are don't-care until counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr]   <= in_x;
            mem_y[wr_ptr]   <= in_y;
            mem_sel[wr_ptr] <= in_sel;
        end
    end

    // Pointers and occupancy; full/empty come from count only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (load)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !load)
                count <= count + CW'(1);
            else if (load && !push)
                count <= count - CW'(1);
        end
    end

    // Result register: load from the ALU, otherwise hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
            res_dz    <= 1'b0;
        end else if (load) begin
            res_valid <= 1'b1;
            res_data  <= dz_hit ? {(2*N){1'b1}} : alu_out;
            res_sel   <= alu_sel;
            res_dz    <= dz_hit;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Buffered command front-end for the combinational N-bit ALU stage. It accepts (x, y, sel) commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents the head entry to the ALU's operand/select inputs, then registers the 2N-bit ALU result into an output stage with its own valid/ready handshake. It also traps divide/modulo-by-zero, so downstream logic never consumes an undefined quotient.

## Interface
- N, 4, operand width; ALU result width is 2N
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  queue can accept (count < DEPTH)
- in_x  in  N  operand x
- in_y  in  N  operand y
- in_sel  in  3  ALU opcode (000 add, 001 sub, 010 mul, 011 div, 100 xor, 101 mod, 110 shl1, 111 shr1)
- alu_x  out  N  head operand x to ALU; 0 when empty
- alu_y  out  N  head operand y to ALU; 0 when empty
- alu_sel  out  3  head opcode to ALU; 0 when empty
- alu_out  in  2N  combinational ALU result for alu_x/alu_y/alu_sel
- res_valid  out  1  result register holds a result
- res_ready  in  1  downstream accepts result
- res_data  out  2N  registered result
- res_sel  out  3  opcode that produced res_data
- res_dz  out  1  result was a trapped divide/modulo by zero
- count  out  $clog2(DEPTH+1)  FIFO occupancy (excludes result register)

## Operation
- Reset: wr_ptr=rd_ptr=0, count=0, res_valid=0, res_data=0, res_sel=0, res_dz=0. FIFO storage is not reset. in_ready=1 the cycle after reset.
- Push: in_valid && in_ready writes the command at wr_ptr and increments wr_ptr modulo DEPTH.
- Load condition: count>0 && (!res_valid || res_ready). On a load edge:
  - res_data←alu_out, res_sel←alu_sel, res_valid←1
  - rd_ptr increments modulo DEPTH
- Result handshake: res_valid && res_ready with no load clears res_valid. res_data, res_sel and res_dz hold stable while res_valid && !res_ready.
- count: +1 on push only, −1 on load only, unchanged on push and load in the same edge.
- Divide-by-zero trap: when alu_sel∈{011,101} && alu_y==0 at a load edge, res_data←{2N{1'b1}} and res_dz←1. Otherwise res_dz←0.
- Ordering: results leave strictly in command acceptance order.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from count, never from pointer equality alone.

## Timing
- Latency: a command pushed at edge k into an empty queue with an empty or draining result register appears at res_valid after edge k+1.
- Throughput: one command per cycle in and out with res_ready held high.
- in_ready is registered-state based (count<DEPTH). There is no combinational path from res_ready to in_ready. When full, a push is accepted only after a load has decremented count.
- Push while full (in_valid with in_ready=0): ignored, no state change.
- Empty queue with res_ready=1: res_valid falls after the handshake edge. alu_* outputs read 0.
- rst during operation: all queued commands and any held result are discarded at that edge. Outputs take their reset values in the next cycle.

## Configuration
- ALU_ISSUE_DZ_TRAP_EN defined: the divide/modulo-by-zero trap is active as described above.
- ALU_ISSUE_DZ_TRAP_EN undefined: the trap logic is removed. res_data always captures alu_out unmodified, and res_dz is tied to 0.

## Test plan
- Basic add (N=4, DEPTH=4): after reset, push x=3,y=5,sel=000 at edge 1 with res_ready=1 → res_valid=1 after edge 2, res_data=8'h08, res_sel=000, res_dz=0, count=0.
- Backpressure fill: res_ready=0, push 6 back-to-back commands → exactly 5 accepted (1 in result register, count=4), in_ready=0. Then res_ready=1 → 5 results drain in push order on consecutive cycles, and in_ready returns to 1 one cycle after the first drain.
- Opcode sweep:
  - mul x=15,y=15 → 8'hE1
  - mod x=9,y=4 → 8'h01
  - shl1 x=4'hA → 8'h14
  - sub x=2,y=5 → 8'hFD
  - shr1 x=4'h9 → 8'h04
- Divide by zero: push x=9,y=0,sel=011, then x=9,y=0,sel=101.
  - Macro defined → res_data=8'hFF, res_dz=1 for both.
  - Macro undefined → res_dz=0.
  - A following x=9,y=2,sel=011 → res_data=8'h04, res_dz=0.
- Reset mid-operation: with count=3, res_valid=1, res_ready=0, assert rst for one cycle → res_valid=0, count=0, in_ready=1. A following push x=1,y=1,sel=000 yields res_data=8'h02 two edges later.
- Wrap-around: with res_ready=1, stream 10 commands x=i,y=1,sel=000 (i=0..9) → results 1..10 in order with no gaps, pointers having wrapped twice.
